// File: rtl/branch_target_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_target_predictor: direct-mapped 2-bit direction/target predictor  |
// | with registered lookup and saturating mispredict counter.  Rev 1.0       |
// +--------------------------------------------------------------------------+
module branch_target_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [15:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 30 - INDEX_BITS;

  localparam logic [1:0] STRONG_NOT_TAKEN = 2'b00;
  localparam logic [1:0] WEAK_NOT_TAKEN   = 2'b01;
  localparam logic [1:0] WEAK_TAKEN       = 2'b10;
  localparam logic [1:0] STRONG_TAKEN     = 2'b11;

  logic             valid_q  [0:ENTRIES-1];
  logic             valid_d  [0:ENTRIES-1];
  logic [TAG_W-1:0] tag_q    [0:ENTRIES-1];
  logic [TAG_W-1:0] tag_d    [0:ENTRIES-1];
  logic [1:0]       state_q  [0:ENTRIES-1];
  logic [1:0]       state_d  [0:ENTRIES-1];
  logic [31:0]      target_q [0:ENTRIES-1];
  logic [31:0]      target_d [0:ENTRIES-1];

  logic        pred_valid_q, pred_valid_d;
  logic        pred_taken_q, pred_taken_d;
  logic [31:0] pred_target_q, pred_target_d;
  logic [15:0] count_q, count_d;

  logic [INDEX_BITS-1:0] f_idx, u_idx;
  logic [TAG_W-1:0]      f_tag, u_tag;
  logic                  f_hit, f_taken, u_hit, u_mispredict;
  logic [1:0]            u_old, u_next;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  // Lookup reads the pre-update table, giving read-before-write on collisions.
  always_comb begin
    f_idx         = fetch_pc[INDEX_BITS+1:2];
    f_tag         = fetch_pc[31:INDEX_BITS+2];
    f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    f_taken       = f_hit && state_q[f_idx][1];
    pred_valid_d  = fetch_valid;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (fetch_valid) begin
      pred_taken_d  = f_taken;
      pred_target_d = f_taken ? target_q[f_idx] : fetch_pc + 32'd4;
    end
  end

  always_comb begin
    u_idx        = upd_pc[INDEX_BITS+1:2];
    u_tag        = upd_pc[31:INDEX_BITS+2];
    u_hit        = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_old        = state_q[u_idx];
    // A miss implicitly predicted not-taken.
    u_mispredict = u_hit ? (u_old[1] != upd_taken) : upd_taken;
    case (u_old)
      STRONG_NOT_TAKEN: u_next = u_mispredict ? WEAK_NOT_TAKEN   : STRONG_NOT_TAKEN;
      WEAK_NOT_TAKEN:   u_next = u_mispredict ? STRONG_TAKEN     : STRONG_NOT_TAKEN;
      STRONG_TAKEN:     u_next = u_mispredict ? WEAK_TAKEN       : STRONG_TAKEN;
      WEAK_TAKEN:       u_next = u_mispredict ? STRONG_NOT_TAKEN : STRONG_TAKEN;
      default:          u_next = WEAK_NOT_TAKEN;
    endcase

    valid_d  = valid_q;
    tag_d    = tag_q;
    state_d  = state_q;
    target_d = target_q;
    count_d  = count_q;
    if (upd_valid) begin
      valid_d[u_idx] = 1'b1;
      tag_d[u_idx]   = u_tag;
      state_d[u_idx] = u_hit ? u_next : (upd_taken ? WEAK_TAKEN : WEAK_NOT_TAKEN);
      if (!u_hit || upd_taken) begin
        target_d[u_idx] = upd_target;
      end
      if (u_mispredict && (count_q != 16'hFFFF)) begin
        count_d = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        state_q[i]  <= WEAK_NOT_TAKEN;
        target_q[i] <= 32'd0;
      end
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= 32'd0;
      count_q       <= 16'd0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      state_q       <= state_d;
      target_q      <= target_d;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      count_q       <= count_d;
    end
  end

  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign pred_target      = pred_target_q;
  assign mispredict_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_branch_target_predictor: directed + random stimulus against a          |
// | direction/confidence reference model.  Rev 1.0                            |
// +--------------------------------------------------------------------------+
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [15:0] mispredict_count;

  branch_target_predictor #(.INDEX_BITS(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_valid      (fetch_valid),
    .fetch_pc         (fetch_pc),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  // Model entry: predicted direction plus strong/weak confidence.
  bit          m_valid  [64];
  int unsigned m_tag    [64];
  bit          m_dir    [64];
  bit          m_strong [64];
  logic [31:0] m_target [64];
  int          m_count;

  logic        e_pv;
  logic        e_pt;
  logic [31:0] e_tg;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_dir[i] = 0; m_strong[i] = 0; m_target[i] = 32'd0;
    end
    m_count = 0;
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'h3F);
  endfunction

  task automatic model_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    int  i;
    bit  mp;
    i = idx_of(pc);
    if (m_valid[i] && m_tag[i] == (pc >> 8)) begin
      mp = (m_dir[i] != taken);
      if (m_strong[i]) begin
        if (mp) m_strong[i] = 0;
      end else begin
        // weak: confirm strengthens, contradiction flips to strong opposite
        if (mp) m_dir[i] = !m_dir[i];
        m_strong[i] = 1;
      end
      if (taken) m_target[i] = tgt;
    end else begin
      m_valid[i] = 1; m_tag[i] = pc >> 8; m_target[i] = tgt;
      m_dir[i] = taken; m_strong[i] = 0;
      mp = taken;
    end
    if (mp && m_count < 65535) m_count++;
  endtask

  task automatic step(input logic r, input logic fv, input logic [31:0] fpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utg);
    int i;
    rst = r; fetch_valid = fv; fetch_pc = fpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
    @(posedge clk);
    if (r) begin
      model_reset();
      e_pv = 0; e_pt = 0; e_tg = 32'd0;
    end else begin
      e_pv = fv;
      if (fv) begin
        i = idx_of(fpc);
        e_pt = m_valid[i] && m_tag[i] == (fpc >> 8) && m_dir[i];
        e_tg = e_pt ? m_target[i] : fpc + 32'd4;
      end
      if (uv) model_update(upc, ut, utg);
    end
    #1;
    chk("pred_valid", {31'd0, pred_valid}, {31'd0, e_pv});
    if (e_pv || r) begin
      chk("pred_taken", {31'd0, pred_taken}, {31'd0, e_pt});
      chk("pred_target", pred_target, e_tg);
    end
    chk("mispredict_count", {16'd0, mispredict_count}, m_count);
  endtask

  task automatic fetch(input logic [31:0] pc);
    step(0, 1, pc, 0, 32'd0, 0, 32'd0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    step(0, 0, 32'd0, 1, pc, t, tg);
  endtask

  initial begin
    rst = 1; fetch_valid = 0; fetch_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    model_reset();
    step(1, 1, 32'h100, 1, 32'h100, 1, 32'h200);
    step(1, 0, 32'd0, 0, 32'd0, 0, 32'd0);

    // First lookup after reset misses
    fetch(32'h100);
    chk("reset_miss_target", pred_target, 32'h104);

    // Allocate taken, then strengthen
    upd(32'h100, 1, 32'h200);
    fetch(32'h100);
    chk("alloc_taken_target", pred_target, 32'h200);
    upd(32'h100, 1, 32'h200);
    chk("strong_count", {16'd0, mispredict_count}, 32'd1);

    // FSM walk at 0x40
    upd(32'h40, 1, 32'h300);
    upd(32'h40, 1, 32'h300);
    upd(32'h40, 0, 32'h0);
    upd(32'h40, 0, 32'h0);
    fetch(32'h40);
    chk("snt_target", pred_target, 32'h44);
    upd(32'h40, 1, 32'h310);
    fetch(32'h40);
    upd(32'h40, 1, 32'h320);
    fetch(32'h40);
    chk("walk_st_target", pred_target, 32'h320);

    // Alias replacement
    upd(32'h200, 0, 32'h999);
    fetch(32'h100);
    chk("alias_miss", {31'd0, pred_taken}, 32'd0);
    fetch(32'h200);

    // Same-cycle fetch/update collision
    upd(32'h80, 0, 32'h500);
    step(0, 1, 32'h80, 1, 32'h80, 1, 32'h600);
    chk("rbw_old_state", {31'd0, pred_taken}, 32'd0);
    fetch(32'h80);
    chk("rbw_new_state", {31'd0, pred_taken}, 32'd1);

    // PC wrap
    fetch(32'hFFFF_FFFC);
    chk("wrap_target", pred_target, 32'd0);

    // Randomized mixed traffic on a small pc set to get hits and aliases
    for (int n = 0; n < 400; n++) begin
      logic [31:0] fpc_r, upc_r;
      fpc_r = {22'($urandom_range(0, 3)), 2'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 2'b00};
      upc_r = {22'($urandom_range(0, 3)), 2'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 2'b00};
      step(($urandom_range(0, 99) == 0), 1'($urandom), fpc_r,
           1'($urandom), upc_r, 1'($urandom), $urandom);
    end

    // Saturate the counter with always-missing taken updates
    step(1, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    for (int n = 0; n < 65540; n++) begin
      upd((n + 16) << 8, 1, 32'h1000);
    end
    chk("count_saturated", {16'd0, mispredict_count}, 32'h0000_FFFF);
    upd(32'h7000_0000, 1, 32'h1000);
    chk("count_hold", {16'd0, mispredict_count}, 32'h0000_FFFF);

    // Reset mid-fetch
    fetch(32'h100);
    step(1, 1, 32'h100, 1, 32'h100, 1, 32'h200);
    chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
    chk("rst_count", {16'd0, mispredict_count}, 32'd0);
    fetch(32'h1000);
    chk("post_rst_miss", {31'd0, pred_taken}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_target_predictor.md
# branch_target_predictor

- Fetch-side predictor storage: a direct-mapped table of 2-bit saturating-style prediction states, tags and branch targets.
- Each fetch PC gets a registered taken/target prediction.
- Resolved branches from execute write outcomes back, applying the team's 2-bit prediction FSM transition rule internally.
- Sits between the PC-select stage (reader) and the execute-stage branch resolver (writer). Also keeps a saturating mispredict counter for performance monitoring.

## Interface

Parameters:
- INDEX_BITS, 6, table has 2^INDEX_BITS entries; index = pc[INDEX_BITS+1:2]
- Tag width is derived, not a parameter: tag = pc[31:INDEX_BITS+2], width 30-INDEX_BITS.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_valid  in  1  fetch lookup request this cycle
- fetch_pc  in  32  PC being fetched
- pred_valid  out  1  prediction valid (registered)
- pred_taken  out  1  predicted direction
- pred_target  out  32  predicted next PC
- upd_valid  in  1  resolved branch update this cycle
- upd_pc  in  32  PC of resolved branch
- upd_taken  in  1  actual branch outcome
- upd_target  in  32  actual taken target
- mispredict_count  out  16  saturating count of mispredicted updates

## Operation

- State encoding:
  - STRONG_NOT_TAKEN=2'b00
  - WEAK_NOT_TAKEN=2'b01
  - WEAK_TAKEN=2'b10
  - STRONG_TAKEN=2'b11
  - Predicted direction = state[1].
- Entry fields: valid (1), tag, state (2), target (32).
- Lookup: hit = entry.valid && entry.tag == fetch_pc tag.
  - On hit: pred_taken = state[1]; pred_target = state[1] ? entry.target : fetch_pc+4.
  - On miss: pred_taken=0, pred_target=fetch_pc+4.
- Update hit (valid and tag match): mispredicted = (state[1] != upd_taken).
- Transition table, with mp = mispredicted:
  - STRONG_NOT_TAKEN -> mp ? WEAK_NOT_TAKEN : STRONG_NOT_TAKEN
  - WEAK_NOT_TAKEN -> mp ? STRONG_TAKEN : STRONG_NOT_TAKEN
  - STRONG_TAKEN -> mp ? WEAK_TAKEN : STRONG_TAKEN
  - WEAK_TAKEN -> mp ? STRONG_NOT_TAKEN : STRONG_TAKEN
- Target on update hit: written with upd_target only when upd_taken=1; otherwise unchanged.
- Update miss (invalid or tag mismatch) allocates/overwrites the entry:
  - valid=1, tag=upd_pc tag, target=upd_target
  - state = upd_taken ? WEAK_TAKEN : WEAK_NOT_TAKEN
  - Counted as mispredicted iff upd_taken=1 (a miss predicts not-taken).
- mispredict_count increments by 1 per mispredicted update. Holds at 16'hFFFF (no wrap).
- pc+4 arithmetic is 32-bit modulo: 32'hFFFFFFFC+4 = 0.

## Timing

- Lookup latency 1 cycle:
  - fetch_valid/fetch_pc sampled at edge N.
  - pred_valid/pred_taken/pred_target valid after edge N until edge N+1.
  - pred_valid=0 in any cycle following fetch_valid=0. pred_taken/pred_target hold last value but are don't-care when pred_valid=0.
- Update written at the edge where upd_valid=1. Visible to lookups sampled at the next edge or later.
- Same-edge fetch and update to the same index: read-before-write. The prediction reflects the table contents before that update.
- Fetch and update of different indices in the same cycle are fully independent. No stalls, no backpressure; both ports accept every cycle.
- Reset, evaluated at the rising edge while rst=1:
  - All entries: valid=0, state=WEAK_NOT_TAKEN, tag=0, target=0.
  - pred_valid=0, pred_taken=0, pred_target=0, mispredict_count=0.
  - rst overrides a simultaneous fetch or update; both are discarded.
- Reset mid-operation: any prediction in flight is dropped. pred_valid=0 in the cycle after the reset edge.
- First lookup after rst deasserts always misses.

## Test plan

- Reset then fetch_pc=0x100 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x104; mispredict_count=0.
- Update pc=0x100 taken target=0x200 (miss, allocate WEAK_TAKEN, count=1), then fetch 0x100 -> pred_taken=1, pred_target=0x200. Second taken update -> STRONG_TAKEN, count stays 1.
- FSM walk at pc=0x40:
  - From STRONG_TAKEN, not-taken -> WEAK_TAKEN (count+1).
  - Not-taken again -> STRONG_NOT_TAKEN (count+1); fetch predicts 0x44.
  - Taken -> WEAK_NOT_TAKEN (count+1).
  - Taken -> STRONG_TAKEN (count+1).
- Alias: INDEX_BITS=6, update 0x100 taken, then update 0x200 not-taken (same index, different tag) -> entry replaced with WEAK_NOT_TAKEN; fetch 0x100 misses, pred_taken=0.
- Same-cycle fetch and update of 0x80, with the entry at WEAK_NOT_TAKEN and upd_taken=1 -> that prediction shows pred_taken=0 (old state); fetch of 0x80 on the following edge predicts taken.
- Force 65,540 mispredicted updates -> mispredict_count=16'hFFFF and holds. Assert rst mid-fetch -> pred_valid=0 next cycle, count=0.
